sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, entry width in bits.
REQ-002 SHALL have parameter SIZE, default 64, SRAM depth in entries; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SIZE), SRAM address width.
REQ-004 SHALL have parameter ALMOST_FULL_THRESHOLD, default SIZE-4, almost_full trip level.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enq_valid  in  1  producer offers enq_data.
REQ-008 enq_ready  out  1  block accepts an entry this cycle.
REQ-009 enq_data  in  DATA_WIDTH  entry to enqueue.
REQ-010 deq_valid  out  1  deq_data holds the oldest entry.
REQ-011 deq_ready  in  1  consumer takes deq_data.
REQ-012 deq_data  out  DATA_WIDTH  head entry, registered.
REQ-013 count  out  ADDR_WIDTH+1  total entries held (SRAM plus output register).
REQ-014 almost_full  out  1  count at or above ALMOST_FULL_THRESHOLD.
REQ-015 sram_wr_en / sram_wr_addr / sram_wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  to the 1R1W SRAM write port.
REQ-016 sram_rd_en / sram_rd_addr  out  1 / ADDR_WIDTH  to the SRAM read port.
REQ-017 sram_rd_data  in  DATA_WIDTH  from the SRAM; valid one cycle after sram_rd_en; returns same-cycle write data on an address match.

Function
REQ-018 Enqueue fire = enq_valid & enq_ready; dequeue fire = deq_valid & deq_ready.
REQ-019 enq_ready SHALL be 1 iff sram_count < SIZE, computed from registered state only; a same-cycle dequeue does not free a slot.
REQ-020 On enqueue fire, the block SHALL assert sram_wr_en with sram_wr_addr = wr_ptr and sram_wr_data = enq_data, then increment wr_ptr modulo SIZE.
REQ-021 The block SHALL issue a read (sram_rd_en=1, sram_rd_addr=rd_ptr, rd_ptr+1 modulo SIZE) when (!deq_valid | deq_ready) and sram_count_next_for_read > 0.
REQ-022 sram_count_next_for_read SHALL be sram_count plus the current-cycle enqueue fire, so an enqueue into an empty SRAM is read in the same cycle through the SRAM bypass.
REQ-023 The cycle after a read issue, deq_data SHALL load sram_rd_data and deq_valid SHALL be 1.
REQ-024 A dequeue fire with no read issued SHALL clear deq_valid the next cycle; deq_data holds its value.
REQ-025 sram_count SHALL update by +enqueue fire and -read issue each cycle; both in one cycle leaves it unchanged.
REQ-026 count SHALL equal sram_count + deq_valid; the maximum is SIZE+1.
REQ-027 Latency SHALL be as follows: enqueue into an empty block at cycle N gives deq_valid at N+1; sustained throughput is one entry per cycle in each direction.
REQ-028 Entries SHALL leave in strict enqueue order across pointer wrap-around.
REQ-029 deq_data and deq_valid SHALL NOT change while deq_valid=1 and deq_ready=0.

Reset
REQ-030 While reset=1: wr_ptr=0, rd_ptr=0, sram_count=0, deq_valid=0, deq_data=0, enq_ready=0, sram_wr_en=0, sram_rd_en=0, almost_full=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; enqueue attempts during reset are ignored; SRAM contents are not cleared.
REQ-032 The first cycle after reset deasserts SHALL have enq_ready=1 and count=0.

Configuration
REQ-033 Macro SRAM_FIFO_ALMOST_FULL_EN defined: almost_full SHALL be registered and equal (count_next >= ALMOST_FULL_THRESHOLD).
REQ-034 Macro SRAM_FIFO_ALMOST_FULL_EN undefined: almost_full SHALL be tied 0 and the comparator SHALL be absent; the port remains.

Verification
REQ-035 Empty block, SIZE=4; enqueue 0xA5 at cycle N -> deq_valid=1 and deq_data=0xA5 at N+1; count=1.
REQ-036 deq_ready=0; enqueue 0..4 -> enq_ready=0 after 5 accepts, count=5; then deq_ready=1 -> 0,1,2,3,4 in order, one per cycle.
REQ-037 Full, same-cycle enq_valid=1 and deq_ready=1 -> no enqueue accepted that cycle; enqueue is accepted the next cycle; no data lost or duplicated.
REQ-038 Continuous enq/deq of 20 incrementing values with SIZE=4 (pointer wraps 5x) -> output sequence identical; count steady at 1.
REQ-039 Reset pulse with 3 entries held -> next cycle count=0, deq_valid=0; a subsequent enqueue of 0x11 appears at the next cycle.
REQ-040 With SRAM_FIFO_ALMOST_FULL_EN and threshold 3 -> almost_full rises the cycle count reaches 3 and falls when it drops to 2; without the macro -> always 0.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller that keeps its entries in an external
// 1R1W SRAM and presents the head entry on a registered output stage.
//
// Optional feature macro: SRAM_FIFO_ALMOST_FULL_EN
//   defined   -> almost_full is a registered (count_next >= ALMOST_FULL_THRESHOLD)
//   undefined -> almost_full is tied low and no comparator is built
//
// The SRAM read port has one cycle of latency and forwards same-cycle write
// data on an address match, so an entry written into an empty SRAM can be
// read in the same cycle and appear on the output one cycle later.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH            = 32,
    parameter int SIZE                  = 64,
    parameter int ADDR_WIDTH            = $clog2(SIZE),
    parameter int ALMOST_FULL_THRESHOLD = SIZE - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  sram_wr_en,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data
);

    localparam logic [ADDR_WIDTH:0] SIZE_C = (ADDR_WIDTH + 1)'(SIZE);

    // Registered state
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   sram_count;
    logic                  deq_valid_q;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] data_hold;

    // Per-cycle control
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  rd_issue;
    logic [ADDR_WIDTH:0]   enq_inc;
    logic [ADDR_WIDTH:0]   rd_dec;
    logic [ADDR_WIDTH:0]   read_avail;
    logic [ADDR_WIDTH:0]   sram_count_next;
    logic                  deq_valid_next;

    // Handshake, read-issue and next-state decisions
    always_comb begin
        // A slot only counts as free from registered occupancy; a dequeue in
        // the same cycle does not make room until the following cycle.
        enq_ready  = !reset && (sram_count < SIZE_C);
        enq_fire   = enq_valid && enq_ready;
        deq_fire   = deq_valid_q && deq_ready;

        enq_inc    = {{ADDR_WIDTH{1'b0}}, enq_fire};
        // Including this cycle's enqueue lets an entry written into an empty
        // SRAM be read straight through the SRAM write-to-read bypass.
        read_avail = sram_count + enq_inc;
        rd_issue   = !reset && (!deq_valid_q || deq_ready) && (read_avail != '0);
        rd_dec     = {{ADDR_WIDTH{1'b0}}, rd_issue};

        sram_count_next = sram_count + enq_inc - rd_dec;

        deq_valid_next = deq_valid_q;
        if (rd_issue) begin
            deq_valid_next = 1'b1;
        end else if (deq_fire) begin
            deq_valid_next = 1'b0;
        end
    end

    // SRAM port drive
    always_comb begin
        sram_wr_en   = enq_fire;
        sram_wr_addr = wr_ptr;
        sram_wr_data = enq_data;
        sram_rd_en   = rd_issue;
        sram_rd_addr = rd_ptr;
    end

    // Pointers and SRAM occupancy; pointers wrap naturally since SIZE is 2^ADDR_WIDTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sram_count <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            sram_count <= sram_count_next;
        end
    end

    // Output-stage valid and the marker that SRAM read data is arriving this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            deq_valid_q <= 1'b0;
            rd_pending  <= 1'b0;
        end else begin
            deq_valid_q <= deq_valid_next;
            rd_pending  <= rd_issue;
        end
    end

    // Capture the arriving SRAM word so the head entry stays stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            data_hold <= '0;
        end else if (rd_pending) begin
            data_hold <= sram_rd_data;
        end
    end

    // The SRAM output register supplies the head on the cycle its data
    // arrives; after that the captured copy takes over.
    always_comb begin
        deq_valid = deq_valid_q;
        deq_data  = rd_pending ? sram_rd_data : data_hold;
        count     = sram_count + {{ADDR_WIDTH{1'b0}}, deq_valid_q};
    end

`ifdef SRAM_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH+1:0] AF_THRESH = (ADDR_WIDTH + 2)'(ALMOST_FULL_THRESHOLD);

    logic [ADDR_WIDTH+1:0] count_next;
    logic                  almost_full_q;

    // Total occupancy after this edge, widened so the compare cannot overflow
    always_comb begin
        count_next = {1'b0, sram_count_next} + {{(ADDR_WIDTH + 1){1'b0}}, deq_valid_next};
    end

    // Registered almost-full flag tracks the occupancy that will be visible next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_next >= AF_THRESH);
        end
    end

    assign almost_full = almost_full_q;
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl (SIZE=4, threshold 3) with a
// behavioural 1R1W SRAM and a queue-based scoreboard of expected entries.
module tb_sram_fifo_ctrl;

    localparam int DW   = 16;
    localparam int SZ   = 4;
    localparam int AW   = 2;
    localparam int THR  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enq_valid;
    logic          enq_ready;
    logic [DW-1:0] enq_data;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          sram_wr_en;
    logic [AW-1:0] sram_wr_addr;
    logic [DW-1:0] sram_wr_data;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_data;

    logic [DW-1:0] mem [SZ];

    logic [DW-1:0] exp_q [$];
    int            total  = 0;
    int            passed = 0;

    sram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .SIZE(SZ),
        .ADDR_WIDTH(AW),
        .ALMOST_FULL_THRESHOLD(THR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_data(enq_data),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_data(deq_data),
        .count(count),
        .almost_full(almost_full),
        .sram_wr_en(sram_wr_en),
        .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data),
        .sram_rd_en(sram_rd_en),
        .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, write data forwarded on address match
    always @(posedge clk) begin
        if (sram_rd_en) begin
            if (sram_wr_en && (sram_wr_addr == sram_rd_addr))
                sram_rd_data <= sram_wr_data;
            else
                sram_rd_data <= mem[sram_rd_addr];
        end
        if (sram_wr_en)
            mem[sram_wr_addr] <= sram_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: drive inputs, compare against the model, clock, update the model.
    // Model: occupancy is the scoreboard size; output is valid whenever
    // anything is held; the SRAM holds everything except the output entry.
    task automatic tick(input logic rst_i, input logic ev, input logic [DW-1:0] d, input logic dr);
        int   tcnt;
        int   sc;
        logic dv;
        logic er;
        logic af;
        reset     = rst_i;
        enq_valid = ev;
        enq_data  = d;
        deq_ready = dr;
        #2;
        tcnt = exp_q.size();
        dv   = (tcnt > 0);
        sc   = tcnt - (dv ? 1 : 0);
        er   = !rst_i && (sc < SZ);
`ifdef SRAM_FIFO_ALMOST_FULL_EN
        af   = (tcnt >= THR);
`else
        af   = 1'b0;
`endif
        check("enq_ready", {31'd0, enq_ready}, {31'd0, er});
        check("count", {29'd0, count}, tcnt);
        check("deq_valid", {31'd0, deq_valid}, {31'd0, dv});
        check("almost_full", {31'd0, almost_full}, {31'd0, af});
        check("sram_wr_en", {31'd0, sram_wr_en}, {31'd0, ev && er});
        if (dv)
            check("deq_data", {16'd0, deq_data}, {16'd0, exp_q[0]});
        @(posedge clk);
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (dv && dr)
                void'(exp_q.pop_front());
            if (ev && er)
                exp_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] dval;
        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds everything idle; an enqueue attempt is ignored
        tick(1'b1, 1'b1, 16'h0077, 1'b0);
        check("rst_deq_data", {16'd0, deq_data}, 32'd0);
        check("rst_rd_en", {31'd0, sram_rd_en}, 32'd0);
        tick(1'b1, 1'b1, 16'h0078, 1'b1);

        // First cycle out of reset: ready, empty
        tick(1'b0, 1'b0, 16'h0000, 1'b0);

        // Single entry appears on the next cycle
        tick(1'b0, 1'b1, 16'h00A5, 1'b0);
        check("a5_valid", {31'd0, deq_valid}, 32'd1);
        check("a5_data", {16'd0, deq_data}, 32'h00A5);
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);

        // Fill to SIZE+1 with the consumer stalled; the sixth offer is refused
        for (int i = 0; i < 6; i++)
            tick(1'b0, 1'b1, DW'(i), 1'b0);
        check("full_count", {29'd0, count}, 32'd5);

        // Full with simultaneous enqueue and dequeue: accepted only next cycle
        tick(1'b0, 1'b1, 16'h0050, 1'b1);
        tick(1'b0, 1'b1, 16'h0050, 1'b1);
        repeat (8) tick(1'b0, 1'b0, 16'h0000, 1'b1);

        // Streaming through with pointer wrap; occupancy stays at one
        for (int i = 0; i < 20; i++)
            tick(1'b0, 1'b1, DW'(16'h0100 + i), 1'b1);
        check("stream_count", {29'd0, count}, 32'd1);
        repeat (2) tick(1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset with three entries held discards them
        for (int i = 0; i < 3; i++)
            tick(1'b0, 1'b1, DW'(16'h0200 + i), 1'b0);
        tick(1'b1, 1'b0, 16'h0000, 1'b0);
        check("post_rst_count", {29'd0, count}, 32'd0);
        check("post_rst_valid", {31'd0, deq_valid}, 32'd0);
        tick(1'b0, 1'b1, 16'h0011, 1'b0);
        check("post_rst_data", {16'd0, deq_data}, 32'h0011);
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);

        // Random traffic
        dval = 16'h1000;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), dval, 1'($urandom_range(0, 2) != 0));
            dval = dval + 1'b1;
        end
        repeat (8) tick(1'b0, 1'b0, 16'h0000, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
